// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funcs,
// datapath select codes and the FSM state enumeration.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;

  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_LUI = 2'b01;
  localparam logic [1:0] WB_MDR = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_REG = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_LUI_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JR
  } state_t;

endpackage

// File: rtl/mc_ctrl_dispatch.sv
// DECODE dispatch: maps the live op/func to the state that follows DECODE.
// Unsupported opcodes and R-type funcs fall back to FETCH as a nop.
module mc_ctrl_dispatch
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output state_t     next_state
);

  always_comb begin
    next_state = S_FETCH;
    case (op)
      OP_R: begin
        case (func)
          FN_ADDU, FN_SUBU: next_state = S_EXEC_R;
          FN_JR:            next_state = S_JR;
          default:          next_state = S_FETCH;
        endcase
      end
      OP_LW, OP_SW: next_state = S_MEM_ADDR;
      OP_BEQ:       next_state = S_BRANCH;
      OP_ORI:       next_state = S_EXEC_I;
      OP_LUI:       next_state = S_LUI_WB;
      OP_JAL:       next_state = S_JAL;
      default:      next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit with memory-wait timeout (WAIT_LIMIT, 0 = none).
// Define MULTICYCLE_CTRL_PERF_EN to add the cycle_cnt/instr_cnt counters.
module multicycle_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        RegWrite,
  output logic [1:0]  RegDst,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcB,
  output logic        ExtOp,
  output logic [2:0]  ALUCtrl,
  output logic        bus_err
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  // state      | meaning
  // FETCH      | instruction read, IR/PC load on mem_ready
  // DECODE     | latch op/func, dispatch
  // EXEC_*/MEM_ADDR | ALU operation; WB_*/LUI_WB/MEM_WB | register write
  // MEM_RD/WR  | data access, waits for mem_ready
  // BRANCH/JAL/JR | PC update (JAL also links $31)

  localparam bit         TIMEOUT_EN = (WAIT_LIMIT > 0);
  localparam logic [7:0] LIMIT_M1   = 8'(WAIT_LIMIT - 1);

  state_t     state, next_state, dispatch_next;
  logic [5:0] op_q, func_q;
  logic [7:0] wait_cnt;
  logic       req_state, timeout;

  mc_ctrl_dispatch u_dispatch (
    .op         (op),
    .func       (func),
    .next_state (dispatch_next)
  );

  assign req_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Completion in the limit cycle wins over the timeout.
  assign timeout = TIMEOUT_EN && req_state && !mem_ready && (wait_cnt == LIMIT_M1);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:    if (mem_ready) next_state = S_DECODE;
      S_DECODE:   next_state = dispatch_next;
      S_EXEC_R:   next_state = S_WB_R;
      S_EXEC_I:   next_state = S_WB_I;
      S_MEM_ADDR: next_state = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)    next_state = S_MEM_WB;
        else if (timeout) next_state = S_FETCH;
      end
      S_MEM_WR:   if (mem_ready || timeout) next_state = S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      op_q     <= '0;
      func_q   <= '0;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == S_DECODE) begin
        op_q   <= op;
        func_q <= func;
      end
      if (!req_state || mem_ready || timeout)
        wait_cnt <= '0;
      else if (wait_cnt != 8'hff)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (state != S_FETCH && next_state == S_FETCH && !timeout)
        instr_cnt <= instr_cnt + 32'd1;
    end
  end
`endif

  always_comb begin
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    PCSrc    = PC_SEQ;
    RegWrite = 1'b0;
    RegDst   = DST_RT;
    MemtoReg = WB_ALU;
    ALUSrcB  = 1'b0;
    ExtOp    = 1'b0;
    ALUCtrl  = 3'b000;
    bus_err  = 1'b0;
    if (!reset) begin
      bus_err = timeout;
      case (state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCSrc   = PC_SEQ;
          end
        end
        S_EXEC_R: begin
          ALUSrcB = 1'b0;
          ALUCtrl = (func_q == FN_SUBU) ? ALU_SUB : ALU_ADD;
        end
        S_WB_R: begin
          RegWrite = 1'b1;
          RegDst   = DST_RD;
          MemtoReg = WB_ALU;
        end
        S_EXEC_I: begin
          ALUSrcB = 1'b1;
          ExtOp   = 1'b0;
          ALUCtrl = ALU_OR;
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemtoReg = WB_ALU;
        end
        S_LUI_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemtoReg = WB_LUI;
        end
        S_MEM_ADDR: begin
          ALUSrcB = 1'b1;
          ExtOp   = 1'b1;
          ALUCtrl = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          mem_sel = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          RegDst   = DST_RT;
          MemtoReg = WB_MDR;
        end
        S_MEM_WR: begin
          mem_req  = 1'b1;
          mem_sel  = 1'b1;
          MemWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcB = 1'b0;
          ALUCtrl = ALU_SUB;
          if (zero) begin
            PCWrite = 1'b1;
            PCSrc   = PC_BR;
          end
        end
        S_JAL: begin
          RegWrite = 1'b1;
          RegDst   = DST_RA;
          MemtoReg = WB_PC;
          PCWrite  = 1'b1;
          PCSrc    = PC_JMP;
        end
        S_JR: begin
          PCWrite = 1'b1;
          PCSrc   = PC_REG;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl (WAIT_LIMIT=4): directed vector table, random
// instruction stream against a per-instruction cycle-script model, reset cases.
module tb_multicycle_ctrl;

  localparam int LIM = 4;

  localparam logic [5:0] OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2b, OP_LUI = 6'h0f;
  localparam logic [5:0] OP_ORI = 6'h0d, OP_BEQ = 6'h04, OP_JAL = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23, FN_JR = 6'h08;
  localparam logic [5:0] G = 6'h3f;

  typedef struct packed {
    logic       mem_req, mem_sel, mem_write, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_b, ext_op;
    logic [2:0] alu_ctrl;
    logic       bus_err;
  } outs_t;

  typedef struct packed {
    logic       rdy;
    logic       z;
    logic [5:0] op;
    logic [5:0] func;
    outs_t      exp;
    logic       done;
  } vec_t;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_sel, MemWrite, IRWrite, PCWrite, RegWrite, ALUSrcB, ExtOp, bus_err;
  logic [1:0] PCSrc, RegDst, MemtoReg;
  logic [2:0] ALUCtrl;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif
  outs_t act;

  int checks = 0, errors = 0;
  int unsigned cyc_exp = 0, instr_exp = 0;
  vec_t tbl[$];
  vec_t q[$];

  multicycle_ctrl #(.WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_sel(mem_sel), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .ALUCtrl(ALUCtrl),
    .bus_err(bus_err)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
  );

  assign act = {mem_req, mem_sel, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite, RegDst,
                MemtoReg, ALUSrcB, ExtOp, ALUCtrl, bus_err};

  always #5 clk = ~clk;

  function automatic outs_t ov(input logic req, sel, mw, irw, pcw, input logic [1:0] pcs,
                               input logic rw, input logic [1:0] rd, m2r,
                               input logic asb, ext, input logic [2:0] alu, input logic be);
    ov = {req, sel, mw, irw, pcw, pcs, rw, rd, m2r, asb, ext, alu, be};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive one cycle, compare mid-cycle, then advance the counter model on the edge.
  task automatic apply(input vec_t v, input logic rst, input string tag, input int idx);
    reset = rst; mem_ready = v.rdy; zero = v.z; op = v.op; func = v.func;
    @(negedge clk);
    checks++;
    if (act !== v.exp) begin
      errors++;
      $display("FAIL %s #%0d outputs: got %b want %b", tag, idx, act, v.exp);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    checks++;
    if (cycle_cnt !== cyc_exp || instr_cnt !== instr_exp) begin
      errors++;
      $display("FAIL %s #%0d perf: got %0d/%0d want %0d/%0d", tag, idx,
               cycle_cnt, instr_cnt, cyc_exp, instr_exp);
    end
`endif
    @(posedge clk);
    #1;
    if (rst) begin
      cyc_exp = 0;
      instr_exp = 0;
    end else begin
      cyc_exp++;
      instr_exp += 32'(v.done);
    end
  endtask

  task automatic row(input logic rdy, z, input logic [5:0] o, f, input outs_t e, input logic d);
    vec_t v;
    v.rdy = rdy; v.z = z; v.op = o; v.func = f; v.exp = e; v.done = d;
    tbl.push_back(v);
  endtask

  task automatic push(input logic rdy, z, input logic [5:0] o, f, input outs_t e, input logic d);
    vec_t v;
    v.rdy = rdy; v.z = z; v.op = o; v.func = f; v.exp = e; v.done = d;
    q.push_back(v);
  endtask

  // One memory request: ready after d idle cycles, or a timeout on wait cycle LIM.
  task automatic mem_wait(input logic data, wr, input logic [5:0] o, f, input logic done_ok,
                          input int maxd, output bit ok);
    int d;
    outs_t e;
    d = $urandom_range(0, maxd);
    ok = 0;
    for (int i = 0; i < LIM; i++) begin
      e = '0; e.mem_req = 1; e.mem_sel = data; e.mem_write = wr;
      if (i == d) begin
        if (!data) begin e.ir_write = 1; e.pc_write = 1; end
        push(1, rbit(), o, f, e, done_ok);
        ok = 1;
        break;
      end
      if (i == LIM - 1) e.bus_err = 1;
      push(0, rbit(), o, f, e, 0);
    end
  endtask

  // Cycle script of one instruction as the programmer's model describes it.
  task automatic gen_instr(input int kind);
    logic [5:0] o, f, go, gf;
    bit ok;
    outs_t e;
    logic z;
    o = OP_R; f = 6'($urandom_range(0, 63));
    case (kind)
      0: f = FN_ADDU;
      1: f = FN_SUBU;
      2: f = FN_JR;
      3: o = OP_LW;
      4: o = OP_SW;
      5: o = OP_BEQ;
      6: o = OP_LUI;
      7: o = OP_ORI;
      8: o = OP_JAL;
      9: begin
        o = 6'($urandom_range(0, 63));
        if (o inside {OP_R, OP_LW, OP_SW, OP_LUI, OP_ORI, OP_BEQ, OP_JAL}) o = G;
      end
      default: if (f inside {FN_ADDU, FN_SUBU, FN_JR}) f = G;
    endcase
    ok = 0;
    for (int a = 0; a < 6 && !ok; a++) mem_wait(0, 0, o, f, 0, (a == 5) ? 3 : 5, ok);
    push(rbit(), rbit(), o, f, '0, kind >= 9);
    go = 6'($urandom_range(0, 63)); gf = 6'($urandom_range(0, 63));
    e = '0;
    case (kind)
      0, 1: begin
        e.alu_ctrl = (kind == 1) ? 3'b011 : 3'b010;
        push(rbit(), rbit(), go, gf, e, 0);
        e = '0; e.reg_write = 1; e.reg_dst = 2'b01;
        push(rbit(), rbit(), go, gf, e, 1);
      end
      2: begin
        e.pc_write = 1; e.pc_src = 2'b11;
        push(rbit(), rbit(), go, gf, e, 1);
      end
      3, 4: begin
        e.alu_src_b = 1; e.ext_op = 1; e.alu_ctrl = 3'b010;
        push(rbit(), rbit(), go, gf, e, 0);
        mem_wait(1, kind == 4, go, gf, kind == 4, 5, ok);
        if (kind == 3 && ok) begin
          e = '0; e.reg_write = 1; e.mem_to_reg = 2'b10;
          push(rbit(), rbit(), go, gf, e, 1);
        end
      end
      5: begin
        z = rbit();
        e.alu_ctrl = 3'b011;
        if (z) begin e.pc_write = 1; e.pc_src = 2'b01; end
        push(rbit(), z, go, gf, e, 1);
      end
      6: begin
        e.reg_write = 1; e.mem_to_reg = 2'b01;
        push(rbit(), rbit(), go, gf, e, 1);
      end
      7: begin
        e.alu_src_b = 1; e.alu_ctrl = 3'b001;
        push(rbit(), rbit(), go, gf, e, 0);
        e = '0; e.reg_write = 1;
        push(rbit(), rbit(), go, gf, e, 1);
      end
      8: begin
        e.reg_write = 1; e.reg_dst = 2'b10; e.mem_to_reg = 2'b11;
        e.pc_write = 1; e.pc_src = 2'b10;
        push(rbit(), rbit(), go, gf, e, 1);
      end
      default: ;
    endcase
  endtask

  initial begin
    outs_t fd, fw, mrd, mwr, madr;
    vec_t v;
    fd   = ov(1,0,0,1,1,2'b00,0,2'b00,2'b00,0,0,3'b000,0);
    fw   = ov(1,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0);
    mrd  = ov(1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0);
    mwr  = ov(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,0);
    madr = ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,1,3'b010,0);

    // addu, then lw with 3 wait cycles in MEM_RD
    row(1,0,OP_R,FN_ADDU, fd, 0);
    row(1,1,OP_R,FN_ADDU, '0, 0);
    row(0,0,OP_SW,FN_SUBU, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b010,0), 0);
    row(1,1,G,G, ov(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,0,3'b000,0), 1);
    row(1,0,OP_LW,6'h00, fd, 0);
    row(0,0,OP_LW,6'h00, '0, 0);
    row(1,0,OP_SW,6'h00, madr, 0);
    row(0,0,G,G, mrd, 0);
    row(0,1,G,G, mrd, 0);
    row(0,0,G,G, mrd, 0);
    row(1,0,G,G, mrd, 0);
    row(0,0,G,G, ov(0,0,0,0,0,2'b00,1,2'b00,2'b10,0,0,3'b000,0), 1);
    // beq taken, beq not taken, jal, nop opcode
    row(1,0,OP_BEQ,6'h00, fd, 0);
    row(0,1,OP_BEQ,6'h00, '0, 0);
    row(0,1,G,G, ov(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,0,3'b011,0), 1);
    row(1,1,OP_BEQ,6'h00, fd, 0);
    row(0,1,OP_BEQ,6'h00, '0, 0);
    row(1,0,G,G, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b011,0), 1);
    row(1,0,OP_JAL,6'h00, fd, 0);
    row(0,0,OP_JAL,6'h00, '0, 0);
    row(0,0,G,G, ov(0,0,0,0,1,2'b10,1,2'b10,2'b11,0,0,3'b000,0), 1);
    row(1,0,G,6'h00, fd, 0);
    row(1,1,G,6'h00, '0, 1);
    // sw with memory never ready: timeout on the 4th wait cycle, then FETCH
    row(1,0,OP_SW,6'h00, fd, 0);
    row(0,0,OP_SW,6'h00, '0, 0);
    row(0,0,OP_LW,6'h00, madr, 0);
    row(0,0,G,G, mwr, 0);
    row(0,0,G,G, mwr, 0);
    row(0,0,G,G, mwr, 0);
    row(0,0,G,G, ov(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,0,3'b000,1), 0);
    row(0,0,OP_LUI,6'h00, fw, 0);
    // lui, ori, subu, jr
    row(1,0,OP_LUI,6'h00, fd, 0);
    row(0,0,OP_LUI,6'h00, '0, 0);
    row(0,0,G,G, ov(0,0,0,0,0,2'b00,1,2'b00,2'b01,0,0,3'b000,0), 1);
    row(1,0,OP_ORI,6'h00, fd, 0);
    row(0,0,OP_ORI,6'h00, '0, 0);
    row(0,0,G,G, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,3'b001,0), 0);
    row(0,0,G,G, ov(0,0,0,0,0,2'b00,1,2'b00,2'b00,0,0,3'b000,0), 1);
    row(1,0,OP_R,FN_SUBU, fd, 0);
    row(0,0,OP_R,FN_SUBU, '0, 0);
    row(0,0,G,FN_ADDU, ov(0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,3'b011,0), 0);
    row(0,0,G,G, ov(0,0,0,0,0,2'b00,1,2'b01,2'b00,0,0,3'b000,0), 1);
    row(1,0,OP_R,FN_JR, fd, 0);
    row(0,0,OP_R,FN_JR, '0, 0);
    row(1,0,G,G, ov(0,0,0,0,1,2'b11,0,2'b00,2'b00,0,0,3'b000,0), 1);

    // reset for two cycles with mem_ready high: every output must be 0
    v = '0; v.rdy = 1;
    apply(v, 1, "reset", 0);
    apply(v, 1, "reset", 1);

    foreach (tbl[i]) apply(tbl[i], 0, "table", i);

    for (int n = 0; n < 200; n++) begin
      gen_instr($urandom_range(0, 10));
      foreach (q[i]) apply(q[i], 0, "random", n);
      q.delete();
    end

    // reset in the middle of a pending MEM_RD wait
    v = '0; v.rdy = 1; v.op = OP_LW; v.exp = fd;   apply(v, 0, "rst_mid", 0);
    v = '0; v.op = OP_LW;                           apply(v, 0, "rst_mid", 1);
    v = '0; v.exp = madr;                           apply(v, 0, "rst_mid", 2);
    v = '0; v.exp = mrd;                            apply(v, 0, "rst_mid", 3);
    v = '0; v.rdy = 1;                              apply(v, 1, "rst_mid", 4);
    v = '0; v.rdy = 1;                              apply(v, 1, "rst_mid", 5);
    v = '0; v.exp = fw;                             apply(v, 0, "rst_mid", 6);
    v = '0; v.rdy = 1; v.op = G; v.exp = fd;        apply(v, 0, "rst_mid", 7);
    v = '0; v.op = G; v.done = 1;                   apply(v, 0, "rst_mid", 8);
    v = '0; v.exp = fw;                             apply(v, 0, "rst_mid", 9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
